// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave: one decoded window backed by word memory,
// fixed wait-state insertion and two-cycle ERROR responses.
module ahb_slave_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic        hreadyin,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic        hr_readyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    localparam int          IW        = $clog2(MEM_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS) << 2;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    state_e         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [3:0]     be_q, be_d;
    logic           write_q, write_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    mem_q [MEM_WORDS];

    logic [31:0]    off;
    logic [IW-1:0]  idx_in;
    logic [3:0]     be_in;
    logic           size_ok, align_ok, range_ok, legal;
    logic           sample, accept, commit;
    logic [31:0]    mask_q, merged;
    logic           unused_ok;

    assign unused_ok = ^{hburst, htrans[0]};

    assign off      = haddr - ADDR_BASE;
    assign idx_in   = off[IW+1:2];
    assign size_ok  = (hsize <= 3'd2);
    assign align_ok = (hsize == 3'd1) ? !haddr[0] :
                      (hsize == 3'd2) ? (haddr[1:0] == 2'b00) : 1'b1;
    assign range_ok = (off < WIN_BYTES);
    assign legal    = size_ok && align_ok && range_ok;

    // Address phases are only taken while the slave drives ready high.
    assign sample = (state_q == S_IDLE) || (state_q == S_DATA)
                 || (state_q == S_ERR2);
    assign accept = sample && hsel && hreadyin && htrans[1];
    assign commit = (state_q == S_DATA) && write_q;
    assign mask_q = lane_mask(be_q);

    // Read path sees a write that commits on the same edge.
    assign merged = (commit && (idx_q == idx_in))
                  ? ((mem_q[idx_in] & ~mask_q) | (hwdata & mask_q))
                  : mem_q[idx_in];

    // Byte-lane enables of the incoming address phase.
    always_comb begin
        be_in = 4'b0000;
        unique case (hsize)
            3'd0:    be_in = 4'b0001 << haddr[1:0];
            3'd1:    be_in = haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    be_in = 4'b1111;
            default: be_in = 4'b0000;
        endcase
    end

    // Next-state and pending-transfer capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        write_d = write_q;
        rdata_d = rdata_q;
        if (accept) begin
            idx_d   = idx_in;
            be_d    = be_in;
            write_d = hwrite;
            cnt_d   = 3'(WAIT_STATES);
            rdata_d = merged & lane_mask(be_in);
            if (!legal) begin
                state_d = S_ERR1;
            end else begin
                state_d = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
            end
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_DATA;
                    end
                end
                S_ERR1:  state_d = S_ERR2;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Response outputs decoded from the current state.
    always_comb begin
        hr_readyout = 1'b1;
        hresp       = 1'b0;
        hrdata      = 32'h0;
        unique case (state_q)
            S_WAIT: hr_readyout = 1'b0;
            S_ERR1: begin
                hr_readyout = 1'b0;
                hresp       = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
            S_DATA: hrdata = write_q ? 32'h0 : rdata_q;
            default: ;
        endcase
    end

    // State and pending-slot registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            be_q    <= 4'b0000;
            write_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    // Write commit at the closing edge of a write data phase.
    always_ff @(posedge hclk) begin
        if (!hreset && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances with 0, 1 and 3 wait
// states, a transfer-level reference model and directed vectors.
module tb_ahb_slave_mem;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        bit          rdy;
        bit          rsp;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
    } ex_t;

    logic        hclk = 1'b0;
    logic        hrst_a   [3];
    logic        hsel_a   [3];
    logic        hrdyin_a [3];
    logic        hwrite_a [3];
    logic [1:0]  htrans_a [3];
    logic [2:0]  hsize_a  [3];
    logic [2:0]  hburst_a [3];
    logic [31:0] haddr_a  [3];
    logic [31:0] hwdata_a [3];
    logic [31:0] hrdata_a [3];
    logic        rdy_a    [3];
    logic        resp_a   [3];

    int tests = 0;
    int fails = 0;

    logic [31:0] mm [3][256];
    ex_t         sched [3][8];
    int          len [3];
    bit          started [3];

    logic [31:0] r_rdata [$];
    bit          r_resp [$];
    int          r_wait [$];

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_slave_mem #(
            .ADDR_BASE  (BASE),
            .MEM_WORDS  (256),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) u_dut (
            .hclk       (hclk),
            .hreset     (hrst_a[g]),
            .hsel       (hsel_a[g]),
            .hreadyin   (hrdyin_a[g]),
            .hwrite     (hwrite_a[g]),
            .htrans     (htrans_a[g]),
            .hsize      (hsize_a[g]),
            .hburst     (hburst_a[g]),
            .haddr      (haddr_a[g]),
            .hwdata     (hwdata_a[g]),
            .hr_readyout(rdy_a[g]),
            .hresp      (resp_a[g]),
            .hrdata     (hrdata_a[g])
        );
    end

    function automatic int ws(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic ex_t head(int k);
        ex_t e;
        e.rdy = 1; e.rsp = 0; e.rd = 0; e.wr = 0;
        e.addr = 0; e.size = 0;
        if (len[k] > 0) e = sched[k][0];
        return e;
    endfunction

    function automatic bit legal(logic [31:0] a, logic [2:0] sz);
        logic [31:0] off;
        off = a - BASE;
        if (sz > 3'd2) return 0;
        if ((a % (32'd1 << sz)) != 0) return 0;
        return off < 32'd1024;
    endfunction

    function automatic logic [31:0] exp_rd(int k, ex_t e);
        logic [31:0] v;
        int wi, lane;
        v = 32'h0;
        if (!e.rd) return v;
        wi = int'((e.addr - BASE) >> 2);
        for (int b = 0; b < (1 << e.size); b++) begin
            lane = int'(e.addr[1:0]) + b;
            v[8*lane +: 8] = mm[k][wi][8*lane +: 8];
        end
        return v;
    endfunction

    task automatic push(int k, ex_t e);
        sched[k][len[k]] = e;
        len[k]++;
    endtask

    task automatic model_step(int k);
        ex_t cur, e;
        int wi, lane;
        if (hrst_a[k]) begin
            len[k] = 0;
            started[k] = 1;
            return;
        end
        cur = head(k);
        if (len[k] > 0) begin
            for (int j = 0; j < 7; j++) sched[k][j] = sched[k][j+1];
            len[k]--;
        end
        if (cur.wr) begin
            wi = int'((cur.addr - BASE) >> 2);
            for (int b = 0; b < (1 << cur.size); b++) begin
                lane = int'(cur.addr[1:0]) + b;
                mm[k][wi][8*lane +: 8] = hwdata_a[k][8*lane +: 8];
            end
        end
        if (cur.rdy && hsel_a[k] && hrdyin_a[k] && htrans_a[k][1]) begin
            e.addr = haddr_a[k];
            e.size = hsize_a[k];
            e.rd = 0;
            e.wr = 0;
            if (legal(haddr_a[k], hsize_a[k])) begin
                e.rdy = 0; e.rsp = 0;
                for (int j = 0; j < ws(k); j++) push(k, e);
                e.rdy = 1;
                e.rd = !hwrite_a[k];
                e.wr = hwrite_a[k];
                push(k, e);
            end else begin
                e.rdy = 0; e.rsp = 1;
                push(k, e);
                e.rdy = 1;
                push(k, e);
            end
        end
    endtask

    // Reference model advances on every rising edge.
    initial begin
        for (int k = 0; k < 3; k++) begin
            len[k] = 0;
            started[k] = 0;
        end
        forever begin
            @(posedge hclk);
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    // Every cycle, every instance is compared with the model.
    initial begin
        ex_t e;
        logic [31:0] er;
        forever begin
            @(negedge hclk);
            for (int k = 0; k < 3; k++) begin
                if (started[k]) begin
                    e = head(k);
                    er = exp_rd(k, e);
                    tests++;
                    if (rdy_a[k] !== e.rdy || resp_a[k] !== e.rsp
                        || hrdata_a[k] !== er) begin
                        fails++;
                        $display("FAIL cycle_d%0d t=%0t: rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                                 k, $time, rdy_a[k], resp_a[k], hrdata_a[k],
                                 e.rdy, e.rsp, er);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic beat_t bt(logic sel, logic [1:0] tr, logic wr,
                                 logic [2:0] sz, logic [31:0] a,
                                 logic [31:0] d);
        beat_t b;
        b.sel = sel; b.trans = tr; b.wr = wr;
        b.size = sz; b.addr = a; b.data = d;
        return b;
    endfunction

    task automatic drive(int k, beat_t b);
        hsel_a[k]   = b.sel;
        htrans_a[k] = b.trans;
        hwrite_a[k] = b.wr;
        hsize_a[k]  = b.size;
        haddr_a[k]  = b.addr;
    endtask

    // Pipelined master: beat i's address phase overlaps beat i-1's
    // data phase. Records each beat's final-cycle response.
    task automatic run(int k, beat_t bq[$]);
        logic [31:0] pw, rd;
        logic r, rs;
        int waits;
        bit done;
        r_rdata.delete();
        r_resp.delete();
        r_wait.delete();
        pw = 32'h0;
        for (int i = 0; i <= bq.size(); i++) begin
            if (i < bq.size()) drive(k, bq[i]);
            else drive(k, bt(1'b0, 2'd0, 1'b0, 3'd2, BASE, 32'h0));
            hwdata_a[k] = pw;
            waits = 0;
            done = 0;
            while (!done) begin
                @(negedge hclk);
                r = rdy_a[k];
                rd = hrdata_a[k];
                rs = resp_a[k];
                @(posedge hclk);
                #1;
                if (r) begin
                    done = 1;
                end else begin
                    waits++;
                    if (waits > 20) begin
                        tests++;
                        fails++;
                        $display("FAIL stall_d%0d: ready low %0d cycles, want <= 20",
                                 k, waits);
                        done = 1;
                    end
                end
            end
            if (i > 0) begin
                r_rdata.push_back(rd);
                r_resp.push_back(rs);
                r_wait.push_back(waits);
            end
            if (i < bq.size()) pw = bq[i].data;
        end
    endtask

    initial begin
        beat_t q[$];
        for (int k = 0; k < 3; k++) begin
            hrst_a[k] = 1; hsel_a[k] = 0; hrdyin_a[k] = 1;
            hwrite_a[k] = 0; htrans_a[k] = 0; hsize_a[k] = 3'd2;
            hburst_a[k] = 0; haddr_a[k] = BASE; hwdata_a[k] = 0;
        end
        repeat (3) @(posedge hclk);
        #1;
        for (int k = 0; k < 3; k++) hrst_a[k] = 0;
        @(negedge hclk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_d%0d", k),
                {30'h0, rdy_a[k], resp_a[k], hrdata_a[k]},
                {30'h0, 1'b1, 1'b0, 32'h0});
        @(posedge hclk);
        #1;

        // Single write then read, one wait state.
        q = {};
        q.push_back(bt(1, 2'd2, 1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF));
        q.push_back(bt(1, 2'd2, 0, 3'd2, 32'h8000_0004, 32'h0));
        run(1, q);
        chk("wr_wait", r_wait[0], 1);
        chk("rd_wait", r_wait[1], 1);
        chk("wr_resp", r_resp[0], 0);
        chk("rd_resp", r_resp[1], 0);
        chk("rd_data", r_rdata[1], 32'hDEAD_BEEF);

        // Byte lanes.
        q = {};
        q.push_back(bt(1, 2'd2, 1, 3'd2, 32'h8000_0000, 32'h0));
        q.push_back(bt(1, 2'd2, 1, 3'd0, 32'h8000_0001, 32'h0000_8000));
        q.push_back(bt(1, 2'd2, 0, 3'd2, 32'h8000_0000, 32'h0));
        q.push_back(bt(1, 2'd2, 0, 3'd1, 32'h8000_0002, 32'h0));
        run(1, q);
        chk("byte_word_rd", r_rdata[2], 32'h0000_8000);
        chk("half_hi_rd", r_rdata[3], 32'h0);

        // Zero-wait incr4 burst, then forwarded read.
        hburst_a[0] = 3'b011;
        q = {};
        q.push_back(bt(1, 2'd2, 1, 3'd2, 32'h8000_0010, 32'd1));
        q.push_back(bt(1, 2'd3, 1, 3'd2, 32'h8000_0014, 32'd2));
        q.push_back(bt(1, 2'd3, 1, 3'd2, 32'h8000_0018, 32'd3));
        q.push_back(bt(1, 2'd3, 1, 3'd2, 32'h8000_001C, 32'd4));
        q.push_back(bt(1, 2'd2, 0, 3'd2, 32'h8000_001C, 32'h0));
        run(0, q);
        hburst_a[0] = 3'b000;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("burst_wait%0d", i), r_wait[i], 0);
            chk($sformatf("burst_resp%0d", i), r_resp[i], 0);
        end
        chk("burst_fwd_rd", r_rdata[4], 32'h4);

        // Error responses leave memory untouched.
        q = {};
        q.push_back(bt(1, 2'd2, 1, 3'd2, 32'h8000_0000, 32'hAAAA_5555));
        q.push_back(bt(1, 2'd2, 1, 3'd2, 32'h8000_0002, 32'hFFFF_FFFF));
        q.push_back(bt(1, 2'd2, 1, 3'd1, 32'h8000_0401, 32'hFFFF_FFFF));
        q.push_back(bt(1, 2'd2, 1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF));
        q.push_back(bt(1, 2'd2, 1, 3'd2, 32'h7FFF_FFFC, 32'hFFFF_FFFF));
        q.push_back(bt(1, 2'd2, 0, 3'd2, 32'h8000_0000, 32'h0));
        run(1, q);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("err_wait%0d", i), r_wait[i], 1);
            chk($sformatf("err_resp%0d", i), r_resp[i], 1);
        end
        chk("err_mem_kept", r_rdata[5], 32'hAAAA_5555);

        // Idle, busy and unselected address phases.
        q = {};
        q.push_back(bt(1, 2'd0, 1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF));
        q.push_back(bt(1, 2'd1, 1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF));
        q.push_back(bt(0, 2'd2, 1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF));
        q.push_back(bt(1, 2'd2, 0, 3'd2, 32'h8000_0000, 32'h0));
        run(1, q);
        for (int i = 0; i < 3; i++)
            chk($sformatf("idle_resp%0d", i),
                {r_wait[i], 31'h0, r_resp[i], r_rdata[i]}, 64'h0);
        chk("idle_mem_kept", r_rdata[3], 32'hAAAA_5555);

        // Reset in the second wait cycle drops the write.
        q = {};
        q.push_back(bt(1, 2'd2, 1, 3'd2, 32'h8000_0008, 32'h0));
        run(2, q);
        drive(2, bt(1, 2'd2, 1, 3'd2, 32'h8000_0008, 32'h0));
        @(posedge hclk);
        #1;
        drive(2, bt(0, 2'd0, 0, 3'd2, BASE, 32'h0));
        hwdata_a[2] = 32'h1234_5678;
        @(negedge hclk);
        chk("rst_wait1_rdy", rdy_a[2], 0);
        @(posedge hclk);
        #1;
        hrst_a[2] = 1;
        @(posedge hclk);
        #1;
        hrst_a[2] = 0;
        @(negedge hclk);
        chk("rst_mid_out", {30'h0, rdy_a[2], resp_a[2], hrdata_a[2]},
            {30'h0, 1'b1, 1'b0, 32'h0});
        @(posedge hclk);
        #1;
        q = {};
        q.push_back(bt(1, 2'd2, 0, 3'd2, 32'h8000_0008, 32'h0));
        run(2, q);
        chk("rst_dropped_wr", r_rdata[0], 32'h0);

        repeat (2) @(posedge hclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite slave responder: the completion end of the transfers issued by the bridge's AHB master model.
- Decodes one address window, backs it with a word-organised on-chip memory, and inserts a configurable number of wait states.
- Signals ERROR responses for illegal accesses.
- Used as the target for bring-up of the AHB master and as the reference slave before the APB side of the bridge is attached.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte base address of the window (aligned to MEM_WORDS*4).
- MEM_WORDS, 256, number of 32-bit words (power of two, 4..4096).
- WAIT_STATES, 1, number of hr_readyout-low cycles per OKAY data phase (0..7).

Ports:
- hclk  in  1  clock; all logic on the rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select.
- hreadyin  in  1  bus HREADY; when 1, the current address phase is valid.
- hwrite  in  1  1 = write, 0 = read.
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hsize  in  3  0 byte, 1 halfword, 2 word; anything else is illegal.
- hburst  in  3  informational only; it does not change the response.
- haddr  in  32  byte address.
- hwdata  in  32  write data, valid in the data phase.
- hr_readyout  out  1  slave ready; 0 stalls the data phase.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  32  read data.

Behaviour:
- Reset: hr_readyout=1, hresp=0, hrdata=0, FSM=IDLE, no pending transfer. Memory contents are not reset.
- Accept condition: hsel & hreadyin & htrans[1] at a rising edge.
  - On accept, register haddr, hwrite and hsize into the pending slot.
  - IDLE/BUSY, or hsel=0, with hreadyin=1: no transfer; the next cycle gives an OKAY zero-wait response (hr_readyout=1, hresp=0).
- Legality: a transfer is illegal, and never touches memory, if any of the following holds:
  - hsize>2;
  - it is misaligned (hsize=1 with haddr[0]!=0, or hsize=2 with haddr[1:0]!=0);
  - (haddr-ADDR_BASE) >= MEM_WORDS*4, evaluated as a 32-bit unsigned subtraction, so addresses below the base wrap and fail.
- Word index: (haddr-ADDR_BASE)>>2. Byte lanes are little-endian and located by haddr[1:0]:
  - byte uses lane haddr[1:0];
  - halfword uses lanes {haddr[1],0} and {haddr[1],1};
  - word uses all four lanes.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: a legal accept goes to WAIT if WAIT_STATES>0, else DATA. An illegal accept goes to ERR1.
  - WAIT: hr_readyout=0, hresp=0. A counter loaded with WAIT_STATES on accept decrements each cycle; go to DATA when it reaches 1.
  - DATA: hr_readyout=1, hresp=0; the transfer completes this cycle.
    - Write: the enabled lanes of hwdata are committed to memory at the closing edge.
    - Read: hrdata shows the word this cycle, with unaccessed lanes forced to 0.
    - A new accept in the same cycle (pipelined address phase) branches exactly as from IDLE. Otherwise go to IDLE.
  - ERR1: hr_readyout=0, hresp=1. Always go to ERR2.
  - ERR2: hr_readyout=1, hresp=1. Any accept in this cycle is honoured as from IDLE. A master that cancels with IDLE is legal.
- Address phases are only sampled when hr_readyout=1 in the current cycle (i.e. in IDLE, DATA or ERR2). In WAIT and ERR1 the inputs are ignored.
- hrdata=0 in every cycle that is not a read DATA cycle.
- Read-after-write hazard: if a read is accepted on the same edge at which a write commits, the read returns the newly written lanes. Forward from the write path; do not read stale memory.
- Reset asserted mid-transfer:
  - the pending transfer is dropped;
  - a write in WAIT is not committed;
  - outputs take their reset values on the next edge.
- hburst and SEQ/NONSEQ are treated identically. No burst-boundary checking is done; each beat is checked independently.

Test Plan:
- Single write then read, WAIT_STATES=1: word write 32'hDEAD_BEEF at 8000_0004, then word read of 8000_0004 -> each data phase shows hr_readyout 0 for 1 cycle then 1; hrdata=32'hDEAD_BEEF in the read DATA cycle; hresp=0 throughout.
- Byte lanes: word write 32'h0 to 8000_0000, then byte write hwdata=32'h0000_8000 at 8000_0001, then word read -> hrdata=32'h0000_8000. A halfword read at 8000_0002 returns 32'h0.
- Burst, WAIT_STATES=0: incr4 write (NONSEQ then 3 SEQ) at 8000_0010..1C with data 1,2,3,4, immediately followed by a read of 8000_001C -> zero-wait OKAY on every beat; read returns 32'h4 (forwarded from the same-edge commit).
- Errors: word access at 8000_0002, halfword at 8000_0401 (MEM_WORDS=256), and hsize=3 at 8000_0000 -> each gives hr_readyout 0/hresp 1 then 1/1. A following read of the targeted word shows the memory unchanged.
- Idle/busy/unselected: htrans=0, htrans=1, or hsel=0 with htrans=2 -> hr_readyout=1, hresp=0, hrdata=0, no memory change.
- Reset mid-operation: WAIT_STATES=3, word write 32'h1234_5678 to 8000_0008, assert hreset in the 2nd WAIT cycle -> next edge gives hr_readyout=1, hresp=0, hrdata=0. A later read of 8000_0008 does not return 32'h1234_5678 (location pre-filled with 32'h0).
